io_input_conditioner: RTL and testbench
=======================================

IO_INPUT_CONDITIONER -- requirements
Module: io_input_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 50000, consecutive stable cycles needed to accept a new level; legal range 2..65535.
REQ-002 clk  input  1  system clock, shared with the processor core.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 dip_a_raw  input  4  asynchronous DIP switches, low nibble.
REQ-005 dip_b_raw  input  4  asynchronous DIP switches, high nibble.
REQ-006 btn_raw  input  5  asynchronous push buttons, active-high, bouncing.
REQ-007 rd_btn  input  1  one-cycle strobe: core executes lw from the button address (IO_BTN_ADDR).
REQ-008 A_dip_lsb  output  4  debounced dip_a level, read at IO_DIPA_ADDR.
REQ-009 B_dip_msb  output  4  debounced dip_b level, read at IO_DIPB_ADDR.
REQ-010 C_button  output  5  sticky press flags, read at IO_BTN_ADDR.
REQ-011 btn_level  output  5  debounced button level.
REQ-012 btn_press  output  5  one-cycle pulse per debounced 0->1 button transition.

Function
REQ-013 Every raw input bit (13 total) SHALL pass through a 2-flop synchronizer before any other logic.
REQ-014 Each bit SHALL hold a stable register and a counter sized for DEBOUNCE_CYCLES-1.
REQ-015 When the synchronized value equals stable, the counter SHALL clear to 0.
REQ-016 When they differ and the counter is below DEBOUNCE_CYCLES-1, the counter SHALL increment.
REQ-017 When they differ and the counter equals DEBOUNCE_CYCLES-1, stable SHALL take the synchronized value and the counter SHALL clear, in the same edge.
REQ-018 Latency: a clean raw change SHALL appear on the stable output exactly 2+DEBOUNCE_CYCLES clock edges after it occurs.
REQ-019 A raw pulse or glitch of fewer than DEBOUNCE_CYCLES synchronized cycles SHALL NOT change stable.
REQ-020 A_dip_lsb, B_dip_msb and btn_level SHALL be the stable registers directly, with no additional delay.
REQ-021 btn_press[i] SHALL be high for exactly the one cycle after btn_level[i] rises; it is registered, not combinational.
REQ-022 C_button[i] SHALL set on btn_press[i] and hold until cleared.
REQ-023 rd_btn SHALL clear all C_button bits at the next edge.
REQ-024 If rd_btn and btn_press[i] occur in the same cycle, C_button[i] SHALL end set; other bits SHALL clear.
REQ-025 Button release (1->0) SHALL NOT affect C_button.
REQ-026 The counter SHALL never wrap; it saturates its compare at DEBOUNCE_CYCLES-1 (REQ-017).

Reset
REQ-027 Reset SHALL clear all synchronizer flops, stable registers, counters, btn_press and C_button to 0.
REQ-028 Reset asserted mid-debounce SHALL abandon the count; after release, a held input SHALL take the full 2+DEBOUNCE_CYCLES edges to appear.
REQ-029 A button held through reset SHALL produce one btn_press and set C_button after the REQ-028 latency.

Structure
REQ-030 Shared package io_pkg SHALL hold IO_DIPA_ADDR=4076, IO_DIPB_ADDR=4080, IO_BTN_ADDR=4084, IO_LED_ADDR=4088, IO_7SEG_ADDR=4092 as 32-bit constants.
REQ-031 The core SHALL generate rd_btn by comparing the lw address against IO_BTN_ADDR from io_pkg.
REQ-032 Sub-module debounce_bit SHALL implement one synchronizer+debouncer (REQ-013..019, 026) and be instantiated 13 times.
REQ-033 Edge detection and sticky flags SHALL live in io_input_conditioner itself.

Verification (DEBOUNCE_CYCLES=4)
REQ-034 btn_raw[2] 0->1 held -> btn_level[2]=1 exactly 6 edges later; btn_press=5'b00100 for one cycle; C_button=5'b00100.
REQ-035 btn_raw[0] pulsed high for 3 cycles, then low -> btn_level, btn_press and C_button stay 0.
REQ-036 With C_button=5'b00001, assert rd_btn alone -> C_button=0 next cycle; then rd_btn in the same cycle as btn_press[1] -> C_button=5'b00010.
REQ-037 dip_a_raw 4'h0->4'hA, bouncing for 3 cycles, then stable -> A_dip_lsb=4'hA exactly 6 edges after the last bounce; no intermediate value.
REQ-038 Reset asserted while btn_raw[4] is held and its counter is at 2 -> all outputs 0; after release btn_level[4]=1 after 6 edges, with a single btn_press pulse.
REQ-039 Button released after debounce -> btn_level falls 6 edges later; C_button unchanged, no btn_press.

Source files
------------

// File: rtl/io_pkg.sv
// io_pkg
//   Memory-mapped IO addresses shared between the core and the IO blocks,
//   plus the input widths used by io_input_conditioner.
package io_pkg;

    localparam logic [31:0] IO_DIPA_ADDR = 32'd4076;
    localparam logic [31:0] IO_DIPB_ADDR = 32'd4080;
    localparam logic [31:0] IO_BTN_ADDR  = 32'd4084;
    localparam logic [31:0] IO_LED_ADDR  = 32'd4088;
    localparam logic [31:0] IO_7SEG_ADDR = 32'd4092;

    localparam int N_DIP = 4;
    localparam int N_BTN = 5;
    localparam int N_RAW = 2 * N_DIP + N_BTN;

endpackage

// File: rtl/debounce_bit.sv
// debounce_bit
//   Two-flop synchronizer followed by a counting debouncer for one
//   asynchronous input bit. A new level is accepted only after the
//   synchronized value has differed from the stable level for
//   DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk     system clock
//   reset   synchronous, active-high
//   raw     asynchronous input bit
//   stable  debounced level (registered)
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync_d   = {sync_q[0], raw};
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_q[1] != stable_q) begin
            // Terminal count: accept the new level and restart, so the
            // counter never needs to go past CNT_MAX.
            if (cnt_q == CNT_MAX) begin
                stable_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/io_input_conditioner.sv
// io_input_conditioner
//   Conditions the board DIP switches and push buttons for the core:
//   every bit is synchronized and debounced, button rising edges produce
//   a one-cycle press pulse, and presses are latched into sticky flags
//   that a read of the button address clears.
// Ports:
//   clk        system clock
//   reset      synchronous, active-high
//   dip_a_raw  DIP switches, low nibble (async)
//   dip_b_raw  DIP switches, high nibble (async)
//   btn_raw    push buttons, active-high, bouncing (async)
//   rd_btn     one-cycle strobe, core reads the button address
//   A_dip_lsb  debounced dip_a level
//   B_dip_msb  debounced dip_b level
//   C_button   sticky press flags
//   btn_level  debounced button level
//   btn_press  one-cycle pulse per debounced button press
module io_input_conditioner
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_DIP-1:0] dip_a_raw,
    input  logic [N_DIP-1:0] dip_b_raw,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             rd_btn,
    output logic [N_DIP-1:0] A_dip_lsb,
    output logic [N_DIP-1:0] B_dip_msb,
    output logic [N_BTN-1:0] C_button,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press
);

    logic [N_RAW-1:0] raw_all;
    logic [N_RAW-1:0] stable_all;

    assign raw_all = {btn_raw, dip_b_raw, dip_a_raw};

    for (genvar i = 0; i < N_RAW; i++) begin : g_db
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .reset  (reset),
            .raw    (raw_all[i]),
            .stable (stable_all[i])
        );
    end

    assign A_dip_lsb = stable_all[N_DIP-1:0];
    assign B_dip_msb = stable_all[2*N_DIP-1:N_DIP];
    assign btn_level = stable_all[N_RAW-1:2*N_DIP];

    logic [N_BTN-1:0] btn_prev_q, btn_prev_d;
    logic [N_BTN-1:0] btn_press_q, btn_press_d;
    logic [N_BTN-1:0] c_button_q, c_button_d;

    always_comb begin
        btn_prev_d  = btn_level;
        btn_press_d = btn_level & ~btn_prev_q;
        // A press landing in the same cycle as the read survives the clear.
        c_button_d  = (rd_btn ? '0 : c_button_q) | btn_press_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_prev_q  <= '0;
            btn_press_q <= '0;
            c_button_q  <= '0;
        end else begin
            btn_prev_q  <= btn_prev_d;
            btn_press_q <= btn_press_d;
            c_button_q  <= c_button_d;
        end
    end

    assign btn_press = btn_press_q;
    assign C_button  = c_button_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
module tb_io_input_conditioner;

    localparam int N = 4;

    logic       clk;
    logic       reset;
    logic [3:0] dip_a_raw, dip_b_raw;
    logic [4:0] btn_raw;
    logic       rd_btn;
    logic [3:0] A_dip_lsb, B_dip_msb;
    logic [4:0] C_button, btn_level, btn_press;

    int checks = 0;
    int errors = 0;
    bit model_en = 0;

    io_input_conditioner #(.DEBOUNCE_CYCLES(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .dip_a_raw (dip_a_raw),
        .dip_b_raw (dip_b_raw),
        .btn_raw   (btn_raw),
        .rd_btn    (rd_btn),
        .A_dip_lsb (A_dip_lsb),
        .B_dip_msb (B_dip_msb),
        .C_button  (C_button),
        .btn_level (btn_level),
        .btn_press (btn_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a level is accepted once the last N synchronized
    // samples (raw delayed two edges) all disagree with the current level.
    logic [12:0] m_dly0, m_dly1, m_seen, m_flip, m_stable;
    logic [12:0] m_hist [N];
    logic [4:0]  m_prev, m_press, m_c, m_lvl;

    always @(posedge clk) begin
        if (reset) begin
            m_dly0 = '0; m_dly1 = '0; m_stable = '0;
            for (int k = 0; k < N; k++) m_hist[k] = '0;
            m_prev = '0; m_press = '0; m_c = '0;
        end else begin
            m_lvl   = m_stable[12:8];
            m_c     = (rd_btn ? 5'b0 : m_c) | m_press;
            m_press = m_lvl & ~m_prev;
            m_prev  = m_lvl;
            m_seen  = m_dly1;
            m_dly1  = m_dly0;
            m_dly0  = {btn_raw, dip_b_raw, dip_a_raw};
            for (int k = N - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = m_seen;
            m_flip = '1;
            for (int k = 0; k < N; k++) m_flip &= m_hist[k] ^ m_stable;
            m_stable ^= m_flip;
        end
    end

    always @(negedge clk) begin
        if (model_en) begin
            checks++;
            if ({A_dip_lsb, B_dip_msb, C_button, btn_level, btn_press} !==
                {m_stable[3:0], m_stable[7:4], m_c, m_stable[12:8], m_press}) begin
                errors++;
                if (errors < 12)
                    $display("FAIL model t=%0t got A=%h B=%h C=%b lvl=%b prs=%b expected A=%h B=%h C=%b lvl=%b prs=%b",
                             $time, A_dip_lsb, B_dip_msb, C_button, btn_level, btn_press,
                             m_stable[3:0], m_stable[7:4], m_c, m_stable[12:8], m_press);
            end
        end
    end

    typedef struct {
        logic       rst;
        logic [3:0] da, db;
        logic [4:0] btn;
        logic       rd;
        int         n;
        logic [3:0] ea, eb;
        logic [4:0] ec, el, ep;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [3:0] a, logic [3:0] b, logic [4:0] bt, logic rr,
                                int n, logic [3:0] ea, logic [3:0] eb,
                                logic [4:0] ec, logic [4:0] el, logic [4:0] ep);
        vec_t v;
        v.rst = r; v.da = a; v.db = b; v.btn = bt; v.rd = rr; v.n = n;
        v.ea = ea; v.eb = eb; v.ec = ec; v.el = el; v.ep = ep;
        return v;
    endfunction

    task automatic drive(input logic r, input logic [3:0] a, input logic [3:0] b,
                         input logic [4:0] bt, input logic rr);
        reset = r; dip_a_raw = a; dip_b_raw = b; btn_raw = bt; rd_btn = rr;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [12:0] act, input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        drive(1'b1, 4'h0, 4'h0, 5'b0, 1'b0);
        step(2);
    endtask

    logic [12:0] rnd_raw;

    initial begin
        drive(1'b1, 4'h0, 4'h0, 5'b0, 1'b0);

        //                 rst da    db    btn       rd n  A     B     C         lvl       press
        tbl.push_back(mk(1, 4'h0, 4'h0, 5'b00000, 0, 2, 4'h0, 4'h0, 5'b00000, 5'b00000, 5'b00000));
        tbl.push_back(mk(0, 4'h0, 4'h0, 5'b00100, 0, 5, 4'h0, 4'h0, 5'b00000, 5'b00000, 5'b00000));
        tbl.push_back(mk(0, 4'h0, 4'h0, 5'b00100, 0, 1, 4'h0, 4'h0, 5'b00000, 5'b00100, 5'b00000));
        tbl.push_back(mk(0, 4'h0, 4'h0, 5'b00100, 0, 1, 4'h0, 4'h0, 5'b00000, 5'b00100, 5'b00100));
        tbl.push_back(mk(0, 4'h0, 4'h0, 5'b00100, 0, 1, 4'h0, 4'h0, 5'b00100, 5'b00100, 5'b00000));
        tbl.push_back(mk(0, 4'h0, 4'h0, 5'b00000, 0, 5, 4'h0, 4'h0, 5'b00100, 5'b00100, 5'b00000));
        tbl.push_back(mk(0, 4'h0, 4'h0, 5'b00000, 0, 1, 4'h0, 4'h0, 5'b00100, 5'b00000, 5'b00000));
        tbl.push_back(mk(0, 4'h0, 4'h0, 5'b00000, 0, 2, 4'h0, 4'h0, 5'b00100, 5'b00000, 5'b00000));
        tbl.push_back(mk(0, 4'h0, 4'h0, 5'b00000, 1, 1, 4'h0, 4'h0, 5'b00000, 5'b00000, 5'b00000));
        tbl.push_back(mk(0, 4'h0, 4'h0, 5'b00000, 0, 1, 4'h0, 4'h0, 5'b00000, 5'b00000, 5'b00000));
        tbl.push_back(mk(0, 4'h0, 4'h0, 5'b00001, 0, 3, 4'h0, 4'h0, 5'b00000, 5'b00000, 5'b00000));
        tbl.push_back(mk(0, 4'h0, 4'h0, 5'b00000, 0, 8, 4'h0, 4'h0, 5'b00000, 5'b00000, 5'b00000));
        tbl.push_back(mk(0, 4'hA, 4'h5, 5'b00000, 0, 5, 4'h0, 4'h0, 5'b00000, 5'b00000, 5'b00000));
        tbl.push_back(mk(0, 4'hA, 4'h5, 5'b00000, 0, 1, 4'hA, 4'h5, 5'b00000, 5'b00000, 5'b00000));
        tbl.push_back(mk(0, 4'hA, 4'h5, 5'b00000, 0, 4, 4'hA, 4'h5, 5'b00000, 5'b00000, 5'b00000));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].da, tbl[i].db, tbl[i].btn, tbl[i].rd);
            step(tbl[i].n);
            chk($sformatf("vec%0d A_dip_lsb", i), {9'b0, A_dip_lsb}, {9'b0, tbl[i].ea});
            chk($sformatf("vec%0d B_dip_msb", i), {9'b0, B_dip_msb}, {9'b0, tbl[i].eb});
            chk($sformatf("vec%0d C_button",  i), {8'b0, C_button},  {8'b0, tbl[i].ec});
            chk($sformatf("vec%0d btn_level", i), {8'b0, btn_level}, {8'b0, tbl[i].el});
            chk($sformatf("vec%0d btn_press", i), {8'b0, btn_press}, {8'b0, tbl[i].ep});
        end

        // rd_btn alone clears, then rd_btn coinciding with a press keeps that bit
        do_reset();
        drive(1'b0, 4'h0, 4'h0, 5'b00001, 1'b0);
        step(8);
        chk("rd setup C", {8'b0, C_button}, 13'h01);
        rd_btn = 1'b1; step(1);
        chk("rd alone C", {8'b0, C_button}, 13'h00);
        rd_btn = 1'b0; btn_raw = 5'b00011; step(7);
        chk("rd+press prs", {8'b0, btn_press}, 13'h02);
        chk("rd+press pre C", {8'b0, C_button}, 13'h00);
        rd_btn = 1'b1; step(1);
        chk("rd+press C", {8'b0, C_button}, 13'h02);
        rd_btn = 1'b0; step(1);
        chk("rd+press hold C", {8'b0, C_button}, 13'h02);

        // bouncing DIP: no intermediate value, accepted 6 edges after last bounce
        do_reset();
        drive(1'b0, 4'hA, 4'h0, 5'b0, 1'b0); step(1);
        chk("bounce0 A", {9'b0, A_dip_lsb}, 13'h0);
        dip_a_raw = 4'h0; step(1);
        chk("bounce1 A", {9'b0, A_dip_lsb}, 13'h0);
        dip_a_raw = 4'hA; step(1);
        chk("bounce2 A", {9'b0, A_dip_lsb}, 13'h0);
        dip_a_raw = 4'h0; step(1);
        chk("bounce3 A", {9'b0, A_dip_lsb}, 13'h0);
        dip_a_raw = 4'hA;
        for (int i = 1; i <= 6; i++) begin
            step(1);
            chk($sformatf("settle%0d A", i), {9'b0, A_dip_lsb}, (i == 6) ? 13'hA : 13'h0);
        end

        // reset mid-debounce with button held
        do_reset();
        drive(1'b0, 4'h0, 4'h0, 5'b10000, 1'b0); step(4);
        reset = 1'b1; step(2);
        chk("midrst outs", {C_button, btn_level, btn_press[2:0]}, 13'h0);
        chk("midrst prs", {8'b0, btn_press}, 13'h0);
        reset = 1'b0; step(5);
        chk("midrst lvl early", {8'b0, btn_level}, 13'h00);
        step(1);
        chk("midrst lvl", {8'b0, btn_level}, 13'h10);
        step(1);
        chk("midrst prs1", {8'b0, btn_press}, 13'h10);
        step(1);
        chk("midrst prs2", {8'b0, btn_press}, 13'h00);
        chk("midrst C", {8'b0, C_button}, 13'h10);
        step(3);
        chk("midrst prs3", {8'b0, btn_press}, 13'h00);

        // randomized run against the reference model
        do_reset();
        rnd_raw = '0;
        drive(1'b0, 4'h0, 4'h0, 5'b0, 1'b0);
        model_en = 1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 5) == 0)
                rnd_raw[$urandom_range(0, 12)] ^= 1'b1;
            reset     = ($urandom_range(0, 599) == 0);
            rd_btn    = ($urandom_range(0, 5) == 0);
            dip_a_raw = rnd_raw[3:0];
            dip_b_raw = rnd_raw[7:4];
            btn_raw   = rnd_raw[12:8];
            step(1);
        end
        model_en = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
